// File: rtl/demux_l1_sched_pkg.sv
// demux_l1_sched_pkg: shared state encodings and lane constants for the demux L1 scheduler
package demux_l1_sched_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_STALL = 2'd2} state_t;
  localparam int NUM_LANES = 4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/demux_l1_sched_rr_pick.sv
// rr_pick: first non-full lane scanning from ptr upward (mod 4)
//   ptr in 2, almost_full in 4, lane out 2, found out 1 (any lane free)
module rr_pick
  import demux_l1_sched_pkg::*;
(
  input  logic [SEL_W-1:0]     ptr,
  input  logic [NUM_LANES-1:0] almost_full,
  output logic [SEL_W-1:0]     lane,
  output logic                 found
);
  logic [2*NUM_LANES-1:0] dbl;
  logic [NUM_LANES-1:0] rot;
  logic [SEL_W-1:0] off;
  always_comb begin
    dbl = {almost_full, almost_full};
    rot = dbl[ptr +: NUM_LANES];
    off = !rot[0] ? 2'd0 : !rot[1] ? 2'd1 : !rot[2] ? 2'd2 : 2'd3;
    lane = ptr + off;
    found = ~&almost_full;
  end
endmodule

// File: rtl/demux_l1_sched.sv
// demux_l1_sched: round-robin scheduler feeding the 1->2->4 byte demux tree, skipping full lanes
//   in : clk, reset_L (sync active-low), enable, valid_in, data_in[DATA_W], almost_full[4]
//   out: selector_out[2], valid_out, data_out[DATA_W], pause, err_drop (sticky), state_out[2]
//   DEMUX_SCHED_STATS_EN adds cnt_lane0..cnt_lane3 (saturating per-lane emit counters)
module demux_l1_sched
  import demux_l1_sched_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RR_START = 0
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic                 valid_in,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [NUM_LANES-1:0] almost_full,
  output logic [SEL_W-1:0]     selector_out,
  output logic                 valid_out,
  output logic [DATA_W-1:0]    data_out,
  output logic                 pause,
  output logic                 err_drop,
  output logic [1:0]           state_out
`ifdef DEMUX_SCHED_STATS_EN
  ,
  output logic [7:0]           cnt_lane0,
  output logic [7:0]           cnt_lane1,
  output logic [7:0]           cnt_lane2,
  output logic [7:0]           cnt_lane3
`endif
);
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(RR_START);
  state_t state, nxt;
  logic [SEL_W-1:0] ptr, lane;
  logic [DATA_W-1:0] hold, word;
  logic found, emit, cap, drop;
  rr_pick u_pick (.ptr(ptr), .almost_full(almost_full), .lane(lane), .found(found));
  always_ff @(posedge clk)
    state <= !reset_L ? S_IDLE : nxt;
  always_comb begin
    nxt = S_IDLE;
    emit = 1'b0;
    cap = 1'b0;
    drop = 1'b0;
    word = data_in;
    case (state)
      S_IDLE: begin
        nxt = enable ? S_ACTIVE : S_IDLE;
        drop = valid_in;
      end
      S_ACTIVE: begin
        emit = valid_in & found;
        cap = valid_in & ~found;
        nxt = cap ? S_STALL : enable ? S_ACTIVE : S_IDLE;
      end
      S_STALL: begin
        emit = found;
        word = hold;
        drop = valid_in;
        nxt = !found ? S_STALL : enable ? S_ACTIVE : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      ptr <= PTR_RST;
      selector_out <= '0;
      valid_out <= 1'b0;
      data_out <= '0;
      pause <= 1'b0;
      err_drop <= 1'b0;
      hold <= '0;
    end else begin
      ptr <= emit ? lane + 1'b1 : ptr;
      selector_out <= emit ? lane : selector_out;
      valid_out <= emit;
      data_out <= emit ? word : '0;
      pause <= nxt == S_STALL;
      err_drop <= err_drop | drop;
      hold <= cap ? data_in : hold;
    end
  end
  assign state_out = state;
`ifdef DEMUX_SCHED_STATS_EN
  logic [7:0] cnt [NUM_LANES];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      cnt[i] <= !reset_L ? 8'd0 : (emit && lane == SEL_W'(i) && cnt[i] != 8'hFF) ? cnt[i] + 8'd1 : cnt[i];
  end
  assign cnt_lane0 = cnt[0];
  assign cnt_lane1 = cnt[1];
  assign cnt_lane2 = cnt[2];
  assign cnt_lane3 = cnt[3];
`endif
endmodule
